// File: rtl/tdc_thermo_encoder_if.sv
// Timestamp bus between the TDC delay-line sampler and its consumer.
// The master drives the raw taps and enable. The slave returns the timestamp.
interface tdc_thermo_encoder_if #(
    parameter int unsigned NTAPS    = 200,
    parameter int unsigned CODE_W   = 8,
    parameter int unsigned COARSE_W = 16
);
    logic [NTAPS-1:0]    taps;
    logic                enable;
    logic [CODE_W-1:0]   fine_code;
    logic [COARSE_W-1:0] coarse_time;
    logic                ts_valid;
    logic                ts_ovf;
    logic                busy;

    modport master (
        output taps, enable,
        input  fine_code, coarse_time, ts_valid, ts_ovf, busy
    );

    modport slave (
        input  taps, enable,
        output fine_code, coarse_time, ts_valid, ts_ovf, busy
    );
endinterface

// File: rtl/tdc_thermo_encoder.sv
// Thermometer-to-binary encoder for a CARRY4 delay line.
// Pipeline: double-sync, bubble correct, popcount. A hit/dead-time FSM then emits one timestamp per trigger edge.
module tdc_thermo_encoder #(
    parameter int unsigned NTAPS    = 200,
    parameter int unsigned CODE_W   = 8,
    parameter int unsigned COARSE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tdc_thermo_encoder_if.slave   bus
);
    localparam int unsigned EXT_W = NTAPS + 2;
    localparam logic [2:0]  FILL_DONE = 3'd4;

    typedef enum logic [1:0] {IDLE, REPORT, WAIT_CLEAR} state_t;

    logic [NTAPS-1:0]    s1, s2, b;
    logic [COARSE_W-1:0] ctr, c1, c2, c3, c4;
    logic [CODE_W-1:0]   cnt;
    logic                b0_q;
    logic                enable_q;
    logic [2:0]          fill;
    logic                seen_zero;
    logic                zero_run;
    state_t              state;

    logic [CODE_W-1:0]   fine_code_r;
    logic [COARSE_W-1:0] coarse_time_r;
    logic                ts_valid_r, ts_ovf_r, busy_r;

    logic [EXT_W-1:0]    ext_c;
    logic [NTAPS-1:0]    maj_c;
    logic [CODE_W-1:0]   pop_c;
    logic                data_ok_c;

    // 3-tap majority. Below tap 0 the chain reads as 1. Above the last tap it reads as 0.
    always_comb begin
        ext_c = {1'b0, s2, 1'b1};
        maj_c = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            maj_c[i] = (ext_c[i]   & ext_c[i+1]) |
                       (ext_c[i]   & ext_c[i+2]) |
                       (ext_c[i+1] & ext_c[i+2]);
        end
    end

    always_comb begin
        pop_c = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            pop_c = pop_c + CODE_W'(b[i]);
        end
    end

    assign data_ok_c = (fill == FILL_DONE);

    // Sampling pipeline with the coarse count carried alongside each stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            b        <= '0;
            cnt      <= '0;
            b0_q     <= 1'b0;
            ctr      <= '0;
            c1       <= '0;
            c2       <= '0;
            c3       <= '0;
            c4       <= '0;
            enable_q <= 1'b0;
            fill     <= '0;
        end else begin
            s1       <= bus.taps;
            s2       <= s1;
            b        <= maj_c;
            cnt      <= pop_c;
            b0_q     <= b[0];
            ctr      <= ctr + COARSE_W'(1);
            c1       <= ctr;
            c2       <= c1;
            c3       <= c2;
            c4       <= c3;
            enable_q <= bus.enable;
            if (fill != FILL_DONE) fill <= fill + 3'd1;
        end
    end

    // Hit FSM. A hit only counts after a genuine zero has been observed since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            seen_zero     <= 1'b0;
            zero_run      <= 1'b0;
            fine_code_r   <= '0;
            coarse_time_r <= '0;
            ts_valid_r    <= 1'b0;
            ts_ovf_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            ts_valid_r <= 1'b0;
            if (data_ok_c && !b0_q) seen_zero <= 1'b1;
            case (state)
                IDLE: begin
                    if (data_ok_c && b0_q) begin
                        if (!seen_zero) begin
                            state    <= WAIT_CLEAR;
                            zero_run <= 1'b0;
                            busy_r   <= 1'b1;
                        end else if (enable_q) begin
                            state         <= REPORT;
                            busy_r        <= 1'b1;
                            ts_valid_r    <= 1'b1;
                            fine_code_r   <= cnt;
                            coarse_time_r <= c4;
                            ts_ovf_r      <= (cnt == CODE_W'(NTAPS));
                        end
                    end
                end
                REPORT: begin
                    state    <= WAIT_CLEAR;
                    zero_run <= 1'b0;
                end
                WAIT_CLEAR: begin
                    if (b0_q) begin
                        zero_run <= 1'b0;
                    end else if (zero_run) begin
                        state    <= IDLE;
                        busy_r   <= 1'b0;
                        zero_run <= 1'b0;
                    end else begin
                        zero_run <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fine_code   = fine_code_r;
    assign bus.coarse_time = coarse_time_r;
    assign bus.ts_valid    = ts_valid_r;
    assign bus.ts_ovf      = ts_ovf_r;
    assign bus.busy        = busy_r;
endmodule
